// File: rtl/simd_booth_pkg.sv
// Shared constants, lane layout helpers and FSM state type for the SIMD Booth
// step engine.
package simd_booth_pkg;

   localparam int unsigned ACC_W  = 36;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned PROD_W = 32;
   localparam int unsigned CNT_W  = 5;

   localparam logic [1:0] MODE_1X16    = 2'b00;
   localparam logic [1:0] MODE_2X8     = 2'b01;
   localparam logic [1:0] MODE_4X4     = 2'b10;
   localparam logic [1:0] MODE_ILLEGAL = 2'b11;

   localparam logic [CNT_W-1:0] STEPS_1X16 = 5'd16;
   localparam logic [CNT_W-1:0] STEPS_2X8  = 5'd8;
   localparam logic [CNT_W-1:0] STEPS_4X4  = 5'd4;

   localparam int unsigned LANE_W_1X16    = 16;
   localparam int unsigned LANE_W_2X8     = 8;
   localparam int unsigned LANE_W_4X4     = 4;
   localparam int unsigned LANE_BASE_2X8  = 17;
   localparam int unsigned LANE_BASE_4X4  = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [CNT_W-1:0] step_count(input logic [1:0] mode);
      case (mode)
         MODE_2X8: step_count = STEPS_2X8;
         MODE_4X4: step_count = STEPS_4X4;
         default:  step_count = STEPS_1X16;
      endcase
   endfunction

   // A = 0, q-1 = 0, unused = 0; only the Q fields carry the multiplier.
   function automatic logic [ACC_W-1:0] load_accum(input logic [1:0]        mode,
                                                   input logic [DATA_W-1:0] mult);
      logic [ACC_W-1:0] acc;
      acc = '0;
      case (mode)
         MODE_1X16: acc[16:1] = mult;
         MODE_2X8: begin
            for (int i = 0; i < 2; i++)
               acc[LANE_BASE_2X8*i+1 +: LANE_W_2X8] = mult[LANE_W_2X8*i +: LANE_W_2X8];
         end
         MODE_4X4: begin
            for (int i = 0; i < 4; i++)
               acc[LANE_BASE_4X4*i+1 +: LANE_W_4X4] = mult[LANE_W_4X4*i +: LANE_W_4X4];
         end
         default: acc = '0;
      endcase
      return acc;
   endfunction

   // Each lane's A||Q field is packed contiguously into the product word.
   function automatic logic [PROD_W-1:0] pack_product(input logic [1:0]       mode,
                                                      input logic [ACC_W-1:0] acc);
      logic [PROD_W-1:0] prod;
      prod = '0;
      case (mode)
         MODE_1X16: prod = acc[32:1];
         MODE_2X8: begin
            for (int i = 0; i < 2; i++)
               prod[16*i +: 16] = acc[LANE_BASE_2X8*i+1 +: 16];
         end
         MODE_4X4: begin
            for (int i = 0; i < 4; i++)
               prod[8*i +: 8] = acc[LANE_BASE_4X4*i+1 +: 8];
         end
         default: prod = '0;
      endcase
      return prod;
   endfunction

endpackage

// File: rtl/simd_booth_step.sv
// One Booth iteration on the lane-packed accumulator: per-lane add/sub of the
// encoder-selected multiplicand, then per-lane arithmetic right shift.
module simd_booth_step
   import simd_booth_pkg::*;
(
   input  logic [ACC_W-1:0]  i_accum,
   input  logic [DATA_W-1:0] i_enc_m,
   input  logic [3:0]        i_enc_flags,
   input  logic [1:0]        i_mode,
   output logic [ACC_W-1:0]  o_accum_next_c
);

   logic [LANE_W_1X16-1:0]      w_a16;
   logic [1:0][LANE_W_2X8-1:0]  w_a8;
   logic [3:0][LANE_W_4X4-1:0]  w_a4;

   // Lane sums wrap at the lane width, so no carry ever crosses a lane.
   always_comb begin
      o_accum_next_c = i_accum;
      w_a16          = '0;
      w_a8           = '0;
      w_a4           = '0;
      case (i_mode)
         MODE_1X16: begin
            w_a16 = i_enc_flags[0] ? i_accum[32:17] - i_enc_m
                                   : i_accum[32:17] + i_enc_m;
            o_accum_next_c = {3'b000, w_a16[15], w_a16, i_accum[16:1]};
         end
         MODE_2X8: begin
            o_accum_next_c = '0;
            for (int i = 0; i < 2; i++) begin
               w_a8[i] = i_enc_flags[2*i]
                  ? i_accum[LANE_BASE_2X8*i+9 +: 8] - i_enc_m[8*i +: 8]
                  : i_accum[LANE_BASE_2X8*i+9 +: 8] + i_enc_m[8*i +: 8];
               o_accum_next_c[LANE_BASE_2X8*i +: 17] =
                  {w_a8[i][7], w_a8[i], i_accum[LANE_BASE_2X8*i+1 +: 8]};
            end
         end
         MODE_4X4: begin
            for (int i = 0; i < 4; i++) begin
               w_a4[i] = i_enc_flags[i]
                  ? i_accum[LANE_BASE_4X4*i+5 +: 4] - i_enc_m[4*i +: 4]
                  : i_accum[LANE_BASE_4X4*i+5 +: 4] + i_enc_m[4*i +: 4];
               o_accum_next_c[LANE_BASE_4X4*i +: 9] =
                  {w_a4[i][3], w_a4[i], i_accum[LANE_BASE_4X4*i+1 +: 4]};
            end
         end
         default: o_accum_next_c = i_accum;
      endcase
   end

endmodule

// File: rtl/simd_booth_accumulator.sv
// Sequential Booth step engine: holds the lane-packed accumulator for the
// external encoder, iterates N steps and returns packed signed products.
module simd_booth_accumulator
   import simd_booth_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [1:0]           i_mode,
   input  logic [DATA_W-1:0]    i_multiplicand,
   input  logic [DATA_W-1:0]    i_multiplier,
   output logic [ACC_W-1:0]     o_accum,
   output logic [DATA_W-1:0]    o_mcand_q,
   output logic [1:0]           o_mode_q,
   input  logic [DATA_W-1:0]    i_enc_m,
   input  logic [3:0]           i_enc_flags,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [PROD_W-1:0]    o_product,
   output logic                 o_mode_err
);

   state_t              r_state;
   logic [ACC_W-1:0]    r_accum;
   logic [DATA_W-1:0]   r_mcand;
   logic [1:0]          r_mode;
   logic [CNT_W-1:0]    r_cnt;
   logic [PROD_W-1:0]   r_product;
   logic                r_busy;
   logic                r_done;
   logic                r_mode_err;
   logic [ACC_W-1:0]    w_accum_next;

   simd_booth_step u_step (
      .i_accum        (r_accum),
      .i_enc_m        (i_enc_m),
      .i_enc_flags    (i_enc_flags),
      .i_mode         (r_mode),
      .o_accum_next_c (w_accum_next)
   );

   // DONE accepts a new start exactly like IDLE, giving back-to-back operation.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_accum    <= '0;
         r_mcand    <= '0;
         r_mode     <= MODE_1X16;
         r_cnt      <= '0;
         r_product  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_mode_err <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_mode_err <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (i_start && (i_mode != MODE_ILLEGAL)) begin
                  r_state <= RUN;
                  r_busy  <= 1'b1;
                  r_accum <= load_accum(i_mode, i_multiplier);
                  r_mcand <= i_multiplicand;
                  r_mode  <= i_mode;
                  r_cnt   <= step_count(i_mode);
               end else begin
                  r_state    <= IDLE;
                  r_busy     <= 1'b0;
                  r_mode_err <= i_start;
               end
            end
            RUN: begin
               r_accum <= w_accum_next;
               r_cnt   <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state   <= DONE;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_product <= pack_product(r_mode, w_accum_next);
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_accum    = r_accum;
   assign o_mcand_q  = r_mcand;
   assign o_mode_q   = r_mode;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_product  = r_product;
   assign o_mode_err = r_mode_err;

endmodule

// File: tb/tb_simd_booth_accumulator.sv
// Directed bench for simd_booth_accumulator with a radix-2 Booth encoder model
// closing the accum -> enc_m/enc_flags loop.
module tb_simd_booth_accumulator;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  mode;
   logic [15:0] mcand;
   logic [15:0] mplier;
   logic [35:0] accum;
   logic [15:0] mcand_q;
   logic [1:0]  mode_q;
   logic [15:0] enc_m;
   logic [3:0]  enc_flags;
   logic        busy;
   logic        done;
   logic [31:0] product;
   logic        mode_err;

   int vectors;
   int miscompares;
   int cyc;

   simd_booth_accumulator dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_start        (start),
      .i_mode         (mode),
      .i_multiplicand (mcand),
      .i_multiplier   (mplier),
      .o_accum        (accum),
      .o_mcand_q      (mcand_q),
      .o_mode_q       (mode_q),
      .i_enc_m        (enc_m),
      .i_enc_flags    (enc_flags),
      .o_busy         (busy),
      .o_done         (done),
      .o_product      (product),
      .o_mode_err     (mode_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Radix-2 Booth encoder: {Q0, q-1} = 01 -> +M, 10 -> -M, else no op.
   always_comb begin
      enc_m     = '0;
      enc_flags = '0;
      case (mode_q)
         2'b00: begin
            if (accum[1] != accum[0]) enc_m = mcand_q;
            enc_flags[0] = accum[1] & ~accum[0];
         end
         2'b01: begin
            for (int i = 0; i < 2; i++) begin
               if (accum[17*i+1] != accum[17*i]) enc_m[8*i +: 8] = mcand_q[8*i +: 8];
               enc_flags[2*i] = accum[17*i+1] & ~accum[17*i];
            end
         end
         2'b10: begin
            for (int i = 0; i < 4; i++) begin
               if (accum[9*i+1] != accum[9*i]) enc_m[4*i +: 4] = mcand_q[4*i +: 4];
               enc_flags[i] = accum[9*i+1] & ~accum[9*i];
            end
         end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; start is sampled by the next posedge (edge 0).
   task automatic start_op(input logic [1:0] m, input logic [15:0] mc, input logic [15:0] mp);
      mode   = m;
      mcand  = mc;
      mplier = mp;
      start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start  = 1'b0;
   endtask

   // Counts edges from the start edge (inclusive) until done is seen.
   task automatic wait_done(output int n);
      n = 1;
      while (!done && n < 64) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst    = 1'b1;
      start  = 1'b0;
      mode   = 2'b00;
      mcand  = '0;
      mplier = '0;
      repeat (2) @(negedge clk);
      check("rst_accum",   64'(accum),    64'h0);
      check("rst_mcand",   64'(mcand_q),  64'h0);
      check("rst_mode",    64'(mode_q),   64'h0);
      check("rst_busy",    64'(busy),     64'h0);
      check("rst_done",    64'(done),     64'h0);
      check("rst_product", 64'(product),  64'h0);
      check("rst_moderr",  64'(mode_err), 64'h0);
      rst = 1'b0;
      @(negedge clk);

      // 1x16: 7 * -3
      start_op(2'b00, 16'h0007, 16'hFFFD);
      check("m0_load_accum", 64'(accum),   64'h0_0001_FFFA);
      check("m0_load_mcand", 64'(mcand_q), 64'h7);
      check("m0_busy",       64'(busy),    64'h1);
      wait_done(cyc);
      check("m0_latency", 64'(cyc),     64'd17);
      check("m0_product", 64'(product), 64'hFFFF_FFEB);
      check("m0_busy_dn", 64'(busy),    64'h0);
      @(negedge clk);
      check("m0_done_pulse", 64'(done), 64'h0);

      // 2x8: (-5, 12) * (3, -7)
      start_op(2'b01, 16'hFB0C, 16'h03F9);
      check("m1_load_accum", 64'(accum),  64'h0_000C_01F2);
      check("m1_load_mode",  64'(mode_q), 64'h1);
      wait_done(cyc);
      check("m1_latency", 64'(cyc),     64'd9);
      check("m1_product", 64'(product), 64'hFFF1_FFAC);

      // 4x4
      @(negedge clk);
      start_op(2'b10, 16'h3E71, 16'hC52F);
      wait_done(cyc);
      check("m2_latency", 64'(cyc),     64'd5);
      check("m2_product", 64'(product), 64'hF4F6_0EFF);

      // Asynchronous reset during step 5 of a 1x16 run
      @(negedge clk);
      start_op(2'b00, 16'h0007, 16'hFFFD);
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_busy",    64'(busy),    64'h0);
      check("rst_mid_done",    64'(done),    64'h0);
      check("rst_mid_accum",   64'(accum),   64'h0);
      check("rst_mid_product", 64'(product), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start_op(2'b00, 16'hFF9C, 16'h012C);
      wait_done(cyc);
      check("post_rst_latency", 64'(cyc),     64'd17);
      check("post_rst_product", 64'(product), 64'hFFFF_8AD0);

      // Start pulsed mid-RUN is ignored
      @(negedge clk);
      start_op(2'b01, 16'hFB0C, 16'h03F9);
      repeat (2) @(negedge clk);
      mode   = 2'b00;
      mcand  = 16'h1234;
      mplier = 16'h0005;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      check("ign_mode_q",  64'(mode_q),  64'h1);
      check("ign_mcand_q", 64'(mcand_q), 64'hFB0C);
      wait_done(cyc);
      cyc = cyc + 3;
      check("ign_latency", 64'(cyc),     64'd9);
      check("ign_product", 64'(product), 64'hFFF1_FFAC);
      @(negedge clk);

      // Illegal mode
      start_op(2'b11, 16'h1111, 16'h2222);
      check("err_pulse",   64'(mode_err), 64'h1);
      check("err_busy",    64'(busy),     64'h0);
      check("err_product", 64'(product), 64'hFFF1_FFAC);
      @(negedge clk);
      check("err_pulse_end", 64'(mode_err), 64'h0);
      check("err_busy_end",  64'(busy),     64'h0);

      // Back-to-back: start held during DONE
      start_op(2'b10, 16'h3E71, 16'hC52F);
      wait_done(cyc);
      check("b2b_a_product", 64'(product), 64'hF4F6_0EFF);
      start_op(2'b01, 16'h0A09, 16'hF605);
      check("b2b_busy",    64'(busy),    64'h1);
      check("b2b_mcand_q", 64'(mcand_q), 64'h0A09);
      check("b2b_held",    64'(product), 64'hF4F6_0EFF);
      wait_done(cyc);
      check("b2b_latency", 64'(cyc),     64'd9);
      check("b2b_product", 64'(product), 64'hFF9C_002D);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
